apb_uart_csr: RTL and testbench



---
 rtl/apb_uart_pkg.sv | 36 +++
 rtl/uart_err_tracker.sv | 32 +++
 rtl/apb_uart_csr.sv | 126 ++++++++++++
 tb/tb_apb_uart_csr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared register map, CTRL field layout and STATUS bit indices for the APB UART CSR block.
package apb_uart_pkg;

  localparam logic [4:0] OFF_DIV     = 5'h00;
  localparam logic [4:0] OFF_CTRL    = 5'h04;
  localparam logic [4:0] OFF_STATUS  = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h0C;
  localparam logic [4:0] OFF_CNT_PAR = 5'h10;
  localparam logic [4:0] OFF_CNT_OVR = 5'h14;
  localparam logic [4:0] OFF_CNT_FRM = 5'h18;
  localparam logic [4:0] OFF_ID      = 5'h1C;

  localparam int CTRL_PAR_LSB = 0;
  localparam int CTRL_STOP    = 3;
  localparam int CTRL_TX_EN   = 4;
  localparam int CTRL_RX_EN   = 5;
  localparam int CTRL_W       = 6;

  localparam int ST_PAR = 0;
  localparam int ST_OVR = 1;
  localparam int ST_FRM = 2;
  localparam int ST_W   = 3;

  // Field order mirrors the CTRL register bit layout (rx_en at bit 5 down to parity at 2:0).
  typedef struct packed {
    logic       rx_en;
    logic       tx_en;
    logic       stop;
    logic [2:0] parity;
  } ctrl_t;

  function automatic ctrl_t to_ctrl(input logic [31:0] data);
    return ctrl_t'(data[CTRL_W-1:0]);
  endfunction

endpackage

// File: rtl/uart_err_tracker.sv
// One rx error source: a write-1-to-clear sticky flag plus a saturating event counter.
module uart_err_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             clr_sticky,
  input  logic             clr_cnt,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      // A new event outranks a clear so no error is ever lost.
      if (evt)
        sticky <= 1'b1;
      else if (clr_sticky)
        sticky <= 1'b0;

      if (clr_cnt)
        cnt <= CNT_W'(evt);
      else if (evt && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_uart_csr.sv
// APB control/status register block for the UART: divider, frame format, enables,
// rx error tracking with maskable level interrupt and programmable wait states.
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DIV_W       = 32,
  parameter int          CNT_W       = 8,
  parameter int          WAIT_STATES = 0,
  parameter int          DIV_RST     = 434,
  parameter logic [31:0] ID_VAL      = 32'h5541_0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  input  logic              err_rx,
  input  logic              err_rx_dropped,
  input  logic              err_stop,
  output logic [DIV_W-1:0]  delitel,
  output logic [2:0]        parity_bit_mode,
  output logic              stop_bit_num,
  output logic              tx_en,
  output logic              rx_en,
  output logic              irq
);

  logic [3:0]        wcnt;
  logic              access;
  logic [4:0]        off;
  logic              addr_ok;
  logic              bad;
  logic              wr_ok;
  logic              rd_ok;
  logic [DIV_W-1:0]  div_q;
  ctrl_t             ctrl_q;
  logic [ST_W-1:0]   irq_en;
  logic [ST_W-1:0]   status;
  logic [ST_W-1:0]   evt;
  logic [CNT_W-1:0]  cnt [ST_W];
  logic [31:0]       rdata;

  assign access  = psel & penable;
  // Gated by rst so an in-flight transfer never completes while the block is being reset.
  assign pready  = access & ~rst & (wcnt == 4'(WAIT_STATES));

  assign off     = paddr[4:0];
  assign addr_ok = (paddr[ADDR_W-1:5] == '0) && (paddr[1:0] == 2'b00);
  assign bad     = ~addr_ok | (pwrite & (off == OFF_ID));
  assign pslverr = pready & bad;
  assign wr_ok   = pready & pwrite & ~bad;
  assign rd_ok   = pready & ~pwrite & ~bad;

  always_ff @(posedge clk) begin
    if (rst)
      wcnt <= '0;
    else if (!access || pready)
      wcnt <= '0;
    else
      wcnt <= wcnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DIV_W'(DIV_RST);
      ctrl_q <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && (off == OFF_DIV))
        div_q <= pwdata[DIV_W-1:0];
      if (wr_ok && (off == OFF_CTRL))
        ctrl_q <= to_ctrl(pwdata);
      if (wr_ok && (off == OFF_IRQ_EN))
        irq_en <= pwdata[ST_W-1:0];
      irq <= |(status & irq_en);
    end
  end

  assign evt[ST_PAR] = err_rx;
  assign evt[ST_OVR] = err_rx_dropped;
  assign evt[ST_FRM] = err_stop;

  for (genvar i = 0; i < ST_W; i++) begin : g_trk
    localparam logic [4:0] CNT_OFF = OFF_CNT_PAR + 5'(4 * i);
    uart_err_tracker #(.CNT_W(CNT_W)) u_trk (
      .clk        (clk),
      .rst        (rst),
      .evt        (evt[i]),
      .clr_sticky (wr_ok && (off == OFF_STATUS) && pwdata[i]),
      .clr_cnt    (wr_ok && (off == CNT_OFF)),
      .sticky     (status[i]),
      .cnt        (cnt[i])
    );
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_DIV:     rdata[DIV_W-1:0]  = div_q;
      OFF_CTRL:    rdata[CTRL_W-1:0] = ctrl_q;
      OFF_STATUS:  rdata[ST_W-1:0]   = status;
      OFF_IRQ_EN:  rdata[ST_W-1:0]   = irq_en;
      OFF_CNT_PAR: rdata[CNT_W-1:0]  = cnt[ST_PAR];
      OFF_CNT_OVR: rdata[CNT_W-1:0]  = cnt[ST_OVR];
      OFF_CNT_FRM: rdata[CNT_W-1:0]  = cnt[ST_FRM];
      OFF_ID:      rdata             = ID_VAL;
      default:     rdata             = '0;
    endcase
  end

  assign prdata = rd_ok ? rdata : 32'h0;

  assign delitel         = div_q;
  assign parity_bit_mode = ctrl_q.parity;
  assign stop_bit_num    = ctrl_q.stop;
  assign tx_en           = ctrl_q.tx_en;
  assign rx_en           = ctrl_q.rx_en;

endmodule

// File: tb/tb_apb_uart_csr.sv
// Bench for apb_uart_csr: a zero-wait-state and a three-wait-state instance, expected
// read results queued at issue and checked when the transfer completes.
module tb_apb_uart_csr;
  import apb_uart_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, psel0, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        err_rx, err_rx_dropped, err_stop;
  logic        pready0, pslverr0, pready3, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic [31:0] delitel0, delitel3;
  logic [2:0]  par0, par3;
  logic        stop0, stop3, tx0, tx3, rx0, rx3, irq0, irq3;

  int total = 0;
  int bad   = 0;
  bit cur3  = 1'b0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          rd_chk;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  apb_uart_csr #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .err_rx(err_rx), .err_rx_dropped(err_rx_dropped), .err_stop(err_stop),
    .delitel(delitel0), .parity_bit_mode(par0), .stop_bit_num(stop0),
    .tx_en(tx0), .rx_en(rx0), .irq(irq0)
  );

  apb_uart_csr #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
    .err_rx(err_rx), .err_rx_dropped(err_rx_dropped), .err_stop(err_stop),
    .delitel(delitel3), .parity_bit_mode(par3), .stop_bit_num(stop3),
    .tx_en(tx3), .rx_en(rx3), .irq(irq3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the oldest expectation whenever a transfer finishes.
  always @(negedge clk) begin
    if ((psel0 && penable && pready0) || (psel3 && penable && pready3)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.rd_chk) chk({e.tag, "_rd"}, cur3 ? prdata3 : prdata0, e.rd);
        chk({e.tag, "_err"}, {31'd0, cur3 ? pslverr3 : pslverr0}, {31'd0, e.err});
      end
    end
  end

  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int n;
    sb.push_back('{exp_rd, exp_err, (!wr || exp_err), tag});
    @(posedge clk); #1;
    if (cur3) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(cur3 ? pready3 : pready0) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_wait"}, n, cur3 ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    apb(1'b0, a, 32'h0, exp, 1'b0, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
    apb(1'b1, a, d, 32'h0, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; err_rx = 1'b0; err_rx_dropped = 1'b0; err_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_div", delitel3, 32'd434);
    chk("rst_ctrl", {26'd0, rx3, tx3, stop3, par3}, 32'd0);
    chk("rst_irq", {31'd0, irq3}, 32'd0);
    chk("rst_pready", {31'd0, pready3}, 32'd0);
    chk("rst_prdata", prdata3, 32'd0);

    cur3 = 1'b0;
    rd(12'h000, 32'd434, "r0_div");
    rd(12'h004, 32'd0, "r0_ctrl");
    rd(12'h008, 32'd0, "r0_status");
    rd(12'h00C, 32'd0, "r0_irqen");
    rd(12'h010, 32'd0, "r0_cntpar");
    rd(12'h014, 32'd0, "r0_cntovr");
    rd(12'h018, 32'd0, "r0_cntfrm");
    rd(12'h01C, 32'h5541_0002, "r0_id");

    cur3 = 1'b1;
    wr(12'h000, 32'h1B2, "w_div");
    chk("delitel", delitel3, 32'h1B2);
    rd(12'h000, 32'h1B2, "r_div");
    wr(12'h004, 32'h3D, "w_ctrl");
    chk("ctrl_out", {26'd0, rx3, tx3, stop3, par3}, 32'h3D);
    rd(12'h004, 32'h3D, "r_ctrl");
    wr(12'h00C, 32'h4, "w_irqen");
    rd(12'h00C, 32'h4, "r_irqen");

    @(posedge clk); #1 err_stop = 1'b1;
    @(posedge clk); #1 chk("irq_lat0", {31'd0, irq3}, 32'd0);
    @(posedge clk); #1 err_stop = 1'b0;
    chk("irq_set", {31'd0, irq3}, 32'd1);
    rd(12'h008, 32'h4, "r_status_frm");
    rd(12'h018, 32'd2, "r_cntfrm");
    wr(12'h008, 32'h4, "w1c_frm");
    chk("irq_hold", {31'd0, irq3}, 32'd1);
    @(posedge clk); #1 chk("irq_clr", {31'd0, irq3}, 32'd0);
    rd(12'h008, 32'h0, "r_status_clr");

    @(posedge clk); #1 err_rx = 1'b1;
    repeat (300) @(posedge clk);
    #1 err_rx = 1'b0;
    rd(12'h010, 32'd255, "r_cntpar_sat");
    rd(12'h008, 32'h1, "r_status_par");
    err_rx = 1'b1;
    wr(12'h010, 32'h0, "w_cntpar_clr");
    err_rx = 1'b0;
    rd(12'h010, 32'd1, "r_cntpar_one");
    err_rx = 1'b1;
    wr(12'h008, 32'h1, "w1c_par_race");
    err_rx = 1'b0;
    rd(12'h008, 32'h1, "r_status_race");
    wr(12'h008, 32'h1, "w1c_par");
    rd(12'h008, 32'h0, "r_status_par0");

    @(posedge clk); #1 err_rx_dropped = 1'b1;
    @(posedge clk); #1 err_rx_dropped = 1'b0;
    rd(12'h014, 32'd1, "r_cntovr");
    rd(12'h008, 32'h2, "r_status_ovr");

    apb(1'b0, 12'h020, 32'h0, 32'h0, 1'b1, "e_unmapped");
    apb(1'b0, 12'h006, 32'h0, 32'h0, 1'b1, "e_misalign");
    apb(1'b1, 12'h01C, 32'h1234, 32'h0, 1'b1, "e_wr_id");
    apb(1'b1, 12'h002, 32'hDEAD, 32'h0, 1'b1, "e_wr_misalign");
    apb(1'b1, 12'h104, 32'h0, 32'h0, 1'b1, "e_wr_upper");
    rd(12'h000, 32'h1B2, "r_div_kept");
    rd(12'h004, 32'h3D, "r_ctrl_kept");
    rd(12'h01C, 32'h5541_0002, "r_id");

    wr(12'h004, 32'h0, "w_ctrl0");
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h30;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); chk("abort_rdy_pre", {31'd0, pready3}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_rdy", {31'd0, pready3}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("abort_ctrl", {26'd0, rx3, tx3, stop3, par3}, 32'd0);
    chk("abort_div", delitel3, 32'd434);
    rd(12'h004, 32'h0, "r_ctrl_after_rst");
    rd(12'h008, 32'h0, "r_status_after_rst");

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
